// File: rtl/pipe_pkg.sv
// Shared types for the writeback pipeline latch.
// Packet struct, stage FSM states and reset constants.
package pipe_pkg;

    localparam int IDX_W_DEF  = 5;
    localparam int DATA_W_DEF = 32;
    localparam int REG_NOP    = 0;
    localparam int ZERO_DATA  = 0;

    typedef struct packed {
        logic                  rdE;
        logic [IDX_W_DEF-1:0]  rdIdx;
        logic [DATA_W_DEF-1:0] rdData;
    } wb_pkt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: main entry M (head) and skid entry S.
// Ready is registered so it never depends on downstream ready.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_ready
);

    stage_state_e r_state;
    stage_state_e w_nxt;
    logic [W-1:0] r_m;
    logic [W-1:0] r_s;
    logic         r_rdy;
    logic         w_ld_m;
    logic         w_ld_s;
    logic         w_m_from_s;

    always_comb begin
        w_nxt      = r_state;
        w_ld_m     = 1'b0;
        w_ld_s     = 1'b0;
        w_m_from_s = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (i_push) begin
                    w_nxt  = ONE;
                    w_ld_m = 1'b1;
                end
            end
            ONE: begin
                if (i_push && !i_pop) begin
                    w_nxt  = TWO;
                    w_ld_s = 1'b1;
                end else if (i_push && i_pop) begin
                    w_ld_m = 1'b1;
                end else if (i_pop) begin
                    w_nxt = EMPTY;
                end
            end
            TWO: begin
                if (i_pop) begin
                    w_nxt      = ONE;
                    w_m_from_s = 1'b1;
                end
            end
            default: w_nxt = EMPTY;
        endcase
        // Flush overrides everything, including a same-cycle accept
        if (i_flush) begin
            w_nxt      = EMPTY;
            w_ld_m     = 1'b0;
            w_ld_s     = 1'b0;
            w_m_from_s = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
            r_rdy   <= 1'b1;
            r_m     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_nxt;
            r_rdy   <= (w_nxt != TWO);
            if (i_flush) begin
                r_m <= '0;
                r_s <= '0;
            end else begin
                if (w_ld_m) begin
                    r_m <= i_data;
                end else if (w_m_from_s) begin
                    r_m <= r_s;
                end
                if (w_ld_s) begin
                    r_s <= i_data;
                end
            end
        end
    end

    assign o_data  = r_m;
    assign o_valid = (r_state != EMPTY);
    assign o_ready = r_rdy;

endmodule

// File: rtl/pipe_wb_stage_reg.sv
// Writeback packet latch with valid/ready, flush and x0 suppression.
// Define PIPE_FWD_EN to expose the fwd_* bypass ports.
module pipe_wb_stage_reg
    import pipe_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rdE,
    input  logic [IDX_W-1:0]  in_rdIdx,
    input  logic [DATA_W-1:0] in_rdData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_rdE,
    output logic [IDX_W-1:0]  out_rdIdx,
    output logic [DATA_W-1:0] out_rdData
`ifdef PIPE_FWD_EN
    ,
    output logic              fwd_rdE,
    output logic [IDX_W-1:0]  fwd_rdIdx,
    output logic [DATA_W-1:0] fwd_rdData
`endif
);

    localparam int PW = 1 + IDX_W + DATA_W;

    typedef struct packed {
        logic              rdE;
        logic [IDX_W-1:0]  rdIdx;
        logic [DATA_W-1:0] rdData;
    } pkt_t;

    pkt_t w_pkt_in;
    pkt_t w_head;
    logic w_acc;
    logic w_emit;
    logic w_valid;
    logic w_ready;

    // x0 is hardwired zero, so a write to it is dropped at capture
    assign w_pkt_in.rdE    = in_rdE && (in_rdIdx != IDX_W'(REG_NOP));
    assign w_pkt_in.rdIdx  = in_rdIdx;
    assign w_pkt_in.rdData = in_rdData;

    assign w_acc  = in_valid & w_ready & ~flush_in;
    assign w_emit = w_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [PW-1:0] w_q;

            pipe_skid_buf #(
                .W (PW)
            ) u_buf (
                .i_clk   (clk_in),
                .i_rst_n (rst_in),
                .i_flush (flush_in),
                .i_push  (w_acc),
                .i_pop   (w_emit),
                .i_data  (w_pkt_in),
                .o_data  (w_q),
                .o_valid (w_valid),
                .o_ready (w_ready)
            );

            assign w_head = w_q;
        end else begin : g_single
            logic r_v;
            pkt_t r_m;

            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    r_v <= 1'b0;
                    r_m <= '{1'b0, '0, DATA_W'(ZERO_DATA)};
                end else if (flush_in) begin
                    r_v <= 1'b0;
                    r_m <= '{1'b0, '0, DATA_W'(ZERO_DATA)};
                end else if (w_acc) begin
                    r_v <= 1'b1;
                    r_m <= w_pkt_in;
                end else if (w_emit) begin
                    r_v <= 1'b0;
                end
            end

            assign w_valid = r_v;
            assign w_head  = r_m;
            assign w_ready = ~r_v | out_ready;
        end
    endgenerate

    assign in_ready   = w_ready;
    assign out_valid  = w_valid;
    assign out_rdE    = w_head.rdE;
    assign out_rdIdx  = w_head.rdIdx;
    assign out_rdData = w_head.rdData;

`ifdef PIPE_FWD_EN
    assign fwd_rdE    = w_valid & w_head.rdE;
    assign fwd_rdIdx  = w_head.rdIdx;
    assign fwd_rdData = w_head.rdData;
`endif

endmodule

// File: tb/tb_pipe_wb_stage_reg.sv
// Scoreboard bench for pipe_wb_stage_reg (SKID=1).
// Expected packets queue on accept and are compared on emit.
module tb_pipe_wb_stage_reg;
    import pipe_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        in_valid;
    logic        in_ready;
    logic        in_rdE;
    logic [4:0]  in_rdIdx;
    logic [31:0] in_rdData;
    logic        out_valid;
    logic        out_ready;
    logic        out_rdE;
    logic [4:0]  out_rdIdx;
    logic [31:0] out_rdData;
`ifdef PIPE_FWD_EN
    logic        fwd_rdE;
    logic [4:0]  fwd_rdIdx;
    logic [31:0] fwd_rdData;
`endif

    int n_chk = 0;
    int n_err = 0;
    wb_pkt_t sb[$];

    always #5 clk_in = ~clk_in;

    pipe_wb_stage_reg #(
        .IDX_W  (5),
        .DATA_W (32),
        .SKID   (1)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .flush_in   (flush_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rdE     (in_rdE),
        .in_rdIdx   (in_rdIdx),
        .in_rdData  (in_rdData),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdE    (out_rdE),
        .out_rdIdx  (out_rdIdx),
        .out_rdData (out_rdData)
`ifdef PIPE_FWD_EN
        ,
        .fwd_rdE    (fwd_rdE),
        .fwd_rdIdx  (fwd_rdIdx),
        .fwd_rdData (fwd_rdData)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: observe emit/accept for the cycle, then go to next negedge
    task automatic cyc();
        wb_pkt_t e;
        wb_pkt_t p;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {59'd0, out_rdIdx}, 64'h1_0000);
            end else begin
                e = sb.pop_front();
                chk("sb_rdIdx",  {59'd0, out_rdIdx},  {59'd0, e.rdIdx});
                chk("sb_rdData", {32'd0, out_rdData}, {32'd0, e.rdData});
                chk("sb_rdE",    {63'd0, out_rdE},    {63'd0, e.rdE});
            end
        end
        if (flush_in) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            p.rdE    = in_rdE && (in_rdIdx != 5'd0);
            p.rdIdx  = in_rdIdx;
            p.rdData = in_rdData;
            sb.push_back(p);
        end
        @(negedge clk_in);
    endtask

    task automatic send(input logic [4:0] idx, input logic [31:0] data);
        in_valid  = 1'b1;
        in_rdE    = 1'b1;
        in_rdIdx  = idx;
        in_rdData = data;
        cyc();
        in_valid  = 1'b0;
    endtask

    initial begin
        rst_in    = 1'b0;
        flush_in  = 1'b0;
        in_valid  = 1'b0;
        in_rdE    = 1'b0;
        in_rdIdx  = '0;
        in_rdData = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
        chk("rst_out_rdE",    {63'd0, out_rdE},    64'd0);
        chk("rst_out_rdIdx",  {59'd0, out_rdIdx},  64'd0);
        chk("rst_out_rdData", {32'd0, out_rdData}, 64'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk_in);

        // Streaming, one packet per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("str_in_ready", {63'd0, in_ready}, 64'd1);
            if (i > 0)
                chk("str_out_valid", {63'd0, out_valid}, 64'd1);
            send(5'(i + 1), 32'h10 + 32'(i));
        end
        chk("str_last_valid", {63'd0, out_valid}, 64'd1);
        chk("str_last_idx",   {59'd0, out_rdIdx}, 64'd8);
        cyc();
        chk("str_drained", {63'd0, out_valid}, 64'd0);

        // Stall with two packets held
        out_ready = 1'b0;
        send(5'd3, 32'hAA);
        chk("stl_ready1", {63'd0, in_ready}, 64'd1);
        send(5'd4, 32'hBB);
        chk("stl_ready2", {63'd0, in_ready}, 64'd0);
        chk("stl_head_idx", {59'd0, out_rdIdx}, 64'd3);
        cyc();
        chk("stl_hold_idx",  {59'd0, out_rdIdx},  64'd3);
        chk("stl_hold_data", {32'd0, out_rdData}, 64'hAA);
        out_ready = 1'b1;
        cyc();
        chk("stl_next_idx", {59'd0, out_rdIdx}, 64'd4);
        cyc();
        chk("stl_empty", {63'd0, out_valid}, 64'd0);

        // x0 write suppression
        out_ready = 1'b0;
        send(5'd0, 32'hDEADBEEF);
        chk("x0_valid", {63'd0, out_valid},  64'd1);
        chk("x0_rdE",   {63'd0, out_rdE},    64'd0);
        chk("x0_data",  {32'd0, out_rdData}, 64'hDEADBEEF);
        out_ready = 1'b1;
        cyc();

        // Flush in TWO with a same-cycle accept attempt
        out_ready = 1'b0;
        send(5'd9,  32'h99);
        send(5'd10, 32'hA0);
        flush_in  = 1'b1;
        in_valid  = 1'b1;
        in_rdIdx  = 5'd11;
        in_rdData = 32'hB0;
        cyc();
        flush_in = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_rdE",   {63'd0, out_rdE},   64'd0);
        chk("fl_ready", {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("fl_no_out", {63'd0, out_valid}, 64'd0);
            cyc();
        end

`ifdef PIPE_FWD_EN
        out_ready = 1'b0;
        send(5'd7, 32'h77);
        chk("fwd_rdE_on", {63'd0, fwd_rdE},   64'd1);
        chk("fwd_rdIdx",  {59'd0, fwd_rdIdx}, 64'd7);
        chk("fwd_rdData", {32'd0, fwd_rdData}, 64'h77);
        out_ready = 1'b1;
        cyc();
        chk("fwd_rdE_off", {63'd0, fwd_rdE}, 64'd0);
`endif

        // Reset mid-traffic while holding two packets
        out_ready = 1'b0;
        send(5'd12, 32'hC0);
        send(5'd13, 32'hD0);
        chk("mr_full", {63'd0, in_ready}, 64'd0);
        rst_in = 1'b0;
        #1;
        chk("mr_valid", {63'd0, out_valid},  64'd0);
        chk("mr_data",  {32'd0, out_rdData}, 64'd0);
        sb.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("mr_in_ready", {63'd0, in_ready},  64'd1);
        chk("mr_valid2",   {63'd0, out_valid}, 64'd0);
        @(negedge clk_in);
        out_ready = 1'b1;
        send(5'd14, 32'hE0);
        cyc();

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
